// File: rtl/inst_loader.sv
// inst_loader: turns a UART byte stream into byte writes on the instruction memory port.
// Build option INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after the halt word.
module inst_loader #(
    parameter int                    MEM_SIZE  = 8,
    parameter int                    MEM_LARGE = 256,
    parameter int                    ADDR_SIZE = 8,
    parameter int                    INST_SIZE = 32,
    parameter logic [INST_SIZE-1:0]  HALT_INST = 32'hFFFFFFFF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [MEM_SIZE-1:0]  i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_mem_enable,
    output logic                 o_mem_write_enable,
    output logic [MEM_SIZE-1:0]  o_mem_write_data,
    output logic [ADDR_SIZE-1:0] o_mem_write_addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overflow,
    output logic                 o_drop,
    output logic [ADDR_SIZE-2:0] o_word_count,
    output logic                 o_chk_err,
    output logic [2:0]           o_state
);

    // Handshake: i_rx_valid is a one-cycle strobe with no back-pressure. A byte is
    // taken only in WAIT_BYTE (or CHK_WAIT); one arriving in WRITE/CHECK is lost and
    // latched on o_drop; in IDLE/DONE/ERROR it is silently ignored.
    localparam int CNT_W = ADDR_SIZE - 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BYTE = 3'd1,
        S_WRITE     = 3'd2,
        S_CHECK     = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5,
        S_CHK_WAIT  = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [MEM_SIZE-1:0]   r_byte;
    logic [ADDR_SIZE-1:0]  r_addr;
    logic [ADDR_SIZE-1:0]  r_last_addr;
    logic [INST_SIZE-1:0]  r_asm;
    logic [CNT_W-1:0]      r_word_cnt;
    logic                  r_drop;
    logic                  w_halt;
    logic                  w_last_addr;
    logic                  w_restart;

    assign w_halt      = (r_asm == HALT_INST);
    assign w_last_addr = (r_last_addr == ADDR_SIZE'(MEM_LARGE - 1));
    assign w_restart   = i_start &&
                         (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);

`ifdef INST_LOADER_CHECKSUM_EN
    logic [MEM_SIZE-1:0] r_xsum;
    logic                r_chk_err;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_xsum    <= '0;
            r_chk_err <= 1'b0;
        end else if (w_restart) begin
            r_xsum    <= '0;
            r_chk_err <= 1'b0;
        end else if (r_state == S_WRITE) begin
            r_xsum <= r_xsum ^ r_byte;
        end else if (r_state == S_CHK_WAIT && i_rx_valid && i_rx_data != r_xsum) begin
            r_chk_err <= 1'b1;
        end
    end

    assign o_chk_err = r_chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (i_start) w_next_state = S_WAIT_BYTE;
            S_WAIT_BYTE: if (i_rx_valid) w_next_state = S_WRITE;
            S_WRITE: w_next_state = (r_addr[1:0] == 2'd3) ? S_CHECK : S_WAIT_BYTE;
            S_CHECK: begin
                if (w_halt) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    w_next_state = S_CHK_WAIT;
`else
                    w_next_state = S_DONE;
`endif
                end else if (w_last_addr) begin
                    w_next_state = S_ERROR;
                end else begin
                    w_next_state = S_WAIT_BYTE;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHK_WAIT: if (i_rx_valid) w_next_state = (i_rx_data == r_xsum) ? S_DONE : S_ERROR;
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_enable       = 1'b0;
        o_mem_write_enable = 1'b0;
        o_busy             = 1'b0;
        o_done             = 1'b0;
        o_overflow         = 1'b0;
        case (r_state)
            S_WAIT_BYTE, S_CHECK, S_CHK_WAIT: begin
                o_mem_enable = 1'b1;
                o_busy       = 1'b1;
            end
            S_WRITE: begin
                o_mem_enable       = 1'b1;
                o_mem_write_enable = 1'b1;
                o_busy             = 1'b1;
            end
            S_DONE:  o_done     = 1'b1;
            S_ERROR: o_overflow = 1'b1;
            default: ;
        endcase
    end

    // Word assembly is big-endian: the first byte of a group ends up in the top byte.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_byte      <= '0;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_asm       <= '0;
            r_word_cnt  <= '0;
            r_drop      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_addr     <= '0;
                        r_asm      <= '0;
                        r_word_cnt <= '0;
                        r_drop     <= 1'b0;
                    end
                end
                S_WAIT_BYTE: if (i_rx_valid) r_byte <= i_rx_data;
                S_WRITE: begin
                    r_asm       <= {r_asm[INST_SIZE-MEM_SIZE-1:0], r_byte};
                    r_addr      <= r_addr + ADDR_SIZE'(1);
                    r_last_addr <= r_addr;
                    if (i_rx_valid) r_drop <= 1'b1;
                end
                S_CHECK: begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                    if (i_rx_valid) r_drop <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_write_data = r_byte;
    assign o_mem_write_addr = (r_state == S_WRITE) ? r_addr : r_last_addr;
    assign o_drop           = r_drop;
    assign o_word_count     = r_word_cnt;
    assign o_state          = r_state;

endmodule
